// File: rtl/ctrl_pipe_unit.sv
// Pipelined RV32I control unit: decode in ID, carry control through ID/EX, EX/MEM, MEM/WB.
// Optional macro CTRL_ILLEGAL_TRAP_EN: flag unsupported encodings and squash them into bubbles.
module ctrl_pipe_unit #(
  parameter int INSTR_W       = 32,
  parameter int REG_ADDR_W    = 5,
  parameter int ALU_OP_W      = 2,
  parameter int HAZARD_DETECT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INSTR_W-1:0]    instr_id,
  input  logic                  id_valid,
  input  logic                  hold,
  input  logic                  flush_ex,
  output logic                  stall_out,
  output logic                  illegal_id,
  output logic                  ex_valid,
  output logic [ALU_OP_W-1:0]   ex_alu_op,
  output logic                  ex_alu_src,
  output logic                  ex_alu_src_a,
  output logic                  ex_branch,
  output logic                  ex_is_jal,
  output logic                  ex_is_jalr,
  output logic                  ex_is_lui,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_reg_write,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  wb_reg_write,
  output logic                  wb_memto_reg,
  output logic [REG_ADDR_W-1:0] wb_rd
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [ALU_OP_W-1:0]   alu_op;
    logic                  alu_src;
    logic                  alu_src_a;
    logic                  branch;
    logic                  is_jal;
    logic                  is_jalr;
    logic                  is_lui;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic                  memto_reg;
    logic [REG_ADDR_W-1:0] rd;
  } ex_ctl_t;

  typedef struct packed {
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic                  memto_reg;
    logic [REG_ADDR_W-1:0] rd;
  } mem_ctl_t;

  typedef struct packed {
    logic                  reg_write;
    logic                  memto_reg;
    logic [REG_ADDR_W-1:0] rd;
  } wb_ctl_t;

  logic [6:0]            w_opcode;
  logic [REG_ADDR_W-1:0] w_rd;
  logic [REG_ADDR_W-1:0] w_rs1;
  logic [REG_ADDR_W-1:0] w_rs2;
  logic                  w_unused;
  ex_ctl_t               w_dec;
  logic                  w_known;
  logic                  w_use_rs1;
  logic                  w_use_rs2;
  logic                  w_illegal;
  logic                  w_load_use;
  logic                  w_load;

  logic                  r_vld_p0;
  ex_ctl_t               r_ex_p0;
  mem_ctl_t              r_mem_p1;
  wb_ctl_t               r_wb_p2;

  assign w_opcode = instr_id[6:0];
  assign w_rd     = instr_id[7 +: REG_ADDR_W];
  assign w_rs1    = instr_id[15 +: REG_ADDR_W];
  assign w_rs2    = instr_id[20 +: REG_ADDR_W];
  assign w_unused = ^{instr_id[14:12], instr_id[INSTR_W-1:25]};

  always_comb begin
    w_dec     = '0;
    w_known   = 1'b1;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_dec.rd  = w_rd;
    case (w_opcode)
      OP_R: begin
        w_dec.alu_op = ALU_OP_W'(2);
        w_dec.reg_write = 1'b1;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      OP_I_ALU: begin
        w_dec.alu_op = ALU_OP_W'(2);
        w_dec.alu_src = 1'b1;
        w_dec.reg_write = 1'b1;
        w_use_rs1 = 1'b1;
      end
      OP_LOAD: begin
        w_dec.alu_src = 1'b1;
        w_dec.mem_read = 1'b1;
        w_dec.memto_reg = 1'b1;
        w_dec.reg_write = 1'b1;
        w_use_rs1 = 1'b1;
      end
      OP_STORE: begin
        w_dec.alu_src = 1'b1;
        w_dec.mem_write = 1'b1;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        w_dec.alu_op = ALU_OP_W'(1);
        w_dec.branch = 1'b1;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      OP_JAL: begin
        w_dec.alu_op = ALU_OP_W'(3);
        w_dec.alu_src = 1'b1;
        w_dec.is_jal = 1'b1;
        w_dec.reg_write = 1'b1;
      end
      OP_JALR: begin
        w_dec.alu_op = ALU_OP_W'(3);
        w_dec.alu_src = 1'b1;
        w_dec.is_jalr = 1'b1;
        w_dec.reg_write = 1'b1;
        w_use_rs1 = 1'b1;
      end
      OP_LUI: begin
        w_dec.alu_op = ALU_OP_W'(3);
        w_dec.alu_src = 1'b1;
        w_dec.is_lui = 1'b1;
        w_dec.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        w_dec.alu_op = ALU_OP_W'(3);
        w_dec.alu_src = 1'b1;
        w_dec.alu_src_a = 1'b1;
        w_dec.reg_write = 1'b1;
      end
      default: w_known = 1'b0;
    endcase
    // x0 is hard-wired; never request a write to it
    if (w_rd == '0) w_dec.reg_write = 1'b0;
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign w_illegal = id_valid & ((instr_id[1:0] != 2'b11) | !w_known);
`else
  assign w_illegal = 1'b0;
`endif
  assign illegal_id = !rst & w_illegal;

  // Unknown opcodes use no source registers, so they can never stall
  assign w_load_use = (HAZARD_DETECT != 0) & id_valid & w_known & r_vld_p0 & r_ex_p0.mem_read
                    & (r_ex_p0.rd != '0)
                    & ((w_use_rs1 & (w_rs1 == r_ex_p0.rd)) | (w_use_rs2 & (w_rs2 == r_ex_p0.rd)));
  assign stall_out  = !rst & w_load_use & !flush_ex & !hold;
  assign w_load     = id_valid & !flush_ex & !stall_out & !w_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p0 <= 1'b0;
      r_ex_p0  <= '0;
      r_mem_p1 <= '0;
      r_wb_p2  <= '0;
    end else if (!hold) begin
      // ID -> EX
      r_vld_p0 <= w_load;
      r_ex_p0  <= w_load ? w_dec : '0;
      // EX -> MEM
      r_mem_p1.mem_read  <= r_ex_p0.mem_read;
      r_mem_p1.mem_write <= r_ex_p0.mem_write;
      r_mem_p1.reg_write <= r_ex_p0.reg_write;
      r_mem_p1.memto_reg <= r_ex_p0.memto_reg;
      r_mem_p1.rd        <= r_ex_p0.rd;
      // MEM -> WB
      r_wb_p2.reg_write  <= r_mem_p1.reg_write;
      r_wb_p2.memto_reg  <= r_mem_p1.memto_reg;
      r_wb_p2.rd         <= r_mem_p1.rd;
    end
  end

  assign ex_valid      = r_vld_p0;
  assign ex_alu_op     = r_ex_p0.alu_op;
  assign ex_alu_src    = r_ex_p0.alu_src;
  assign ex_alu_src_a  = r_ex_p0.alu_src_a;
  assign ex_branch     = r_ex_p0.branch;
  assign ex_is_jal     = r_ex_p0.is_jal;
  assign ex_is_jalr    = r_ex_p0.is_jalr;
  assign ex_is_lui     = r_ex_p0.is_lui;
  assign ex_rd         = r_ex_p0.rd;
  assign mem_read      = r_mem_p1.mem_read;
  assign mem_write     = r_mem_p1.mem_write;
  assign mem_reg_write = r_mem_p1.reg_write;
  assign mem_rd        = r_mem_p1.rd;
  assign wb_reg_write  = r_wb_p2.reg_write;
  assign wb_memto_reg  = r_wb_p2.memto_reg;
  assign wb_rd         = r_wb_p2.rd;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Self-checking bench for ctrl_pipe_unit: instruction-level pipeline model plus directed literal checks.
module tb_ctrl_pipe_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_id;
  logic        id_valid, hold, flush_ex;
  logic        stall_out, illegal_id, ex_valid;
  logic [1:0]  ex_alu_op;
  logic        ex_alu_src, ex_alu_src_a, ex_branch, ex_is_jal, ex_is_jalr, ex_is_lui;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic        mem_read, mem_write, mem_reg_write, wb_reg_write, wb_memto_reg;

  always #5 clk = ~clk;

  ctrl_pipe_unit dut (
    .clk(clk), .rst(rst), .instr_id(instr_id), .id_valid(id_valid), .hold(hold),
    .flush_ex(flush_ex), .stall_out(stall_out), .illegal_id(illegal_id), .ex_valid(ex_valid),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_alu_src_a(ex_alu_src_a),
    .ex_branch(ex_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_is_lui(ex_is_lui),
    .ex_rd(ex_rd), .mem_read(mem_read), .mem_write(mem_write), .mem_reg_write(mem_reg_write),
    .mem_rd(mem_rd), .wb_reg_write(wb_reg_write), .wb_memto_reg(wb_memto_reg), .wb_rd(wb_rd)
  );

  localparam logic [31:0] ADDI_X5  = 32'h00100293;
  localparam logic [31:0] LW_X3    = 32'h00012183;
  localparam logic [31:0] ADD_X4   = 32'h00118233;
  localparam logic [31:0] LUI_X3   = 32'h000011B7;
  localparam logic [31:0] JAL_X1   = 32'h000000EF;
  localparam logic [31:0] LW_X0    = 32'h00012003;
  localparam logic [31:0] ADD_X4_0 = 32'h00000233;
  localparam logic [31:0] SW_X3    = 32'h00312023;
  localparam logic [31:0] BEQ      = 32'h00208063;
  localparam logic [31:0] JALR_X1  = 32'h000100E7;
  localparam logic [31:0] AUIPC_X6 = 32'h00000317;
  localparam logic [31:0] NOP      = 32'h00000013;
  localparam logic [31:0] BAD_RS1  = 32'h00018000;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level model: what each stage holds, derived from the opcode table
  typedef struct packed {
    logic v; logic [1:0] op; logic src, srca, br, jal, jalr, lui, mr, mw, rw, m2r; logic [4:0] rd;
  } ctl_t;

  ctl_t m_ex = '0, m_mem = '0, m_wb = '0;
  bit   m_ok = 1'b0;

  function automatic bit is_known(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
  endfunction

  function automatic ctl_t model_dec(input logic [31:0] ins);
    ctl_t c;
    c = '0;
    c.v = 1'b1;
    c.rd = ins[11:7];
    case (ins[6:0])
      7'b0110011: begin c.op = 2; c.rw = 1; end
      7'b0010011: begin c.op = 2; c.src = 1; c.rw = 1; end
      7'b0000011: begin c.src = 1; c.mr = 1; c.m2r = 1; c.rw = 1; end
      7'b0100011: begin c.src = 1; c.mw = 1; end
      7'b1100011: begin c.op = 1; c.br = 1; end
      7'b1101111: begin c.op = 3; c.src = 1; c.jal = 1; c.rw = 1; end
      7'b1100111: begin c.op = 3; c.src = 1; c.jalr = 1; c.rw = 1; end
      7'b0110111: begin c.op = 3; c.src = 1; c.lui = 1; c.rw = 1; end
      7'b0010111: begin c.op = 3; c.src = 1; c.srca = 1; c.rw = 1; end
      default: ;
    endcase
    if (c.rd == 5'd0) c.rw = 1'b0;
    return c;
  endfunction

  function automatic bit exp_illegal();
`ifdef CTRL_ILLEGAL_TRAP_EN
    return !rst && id_valid && !is_known(instr_id);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_stall();
    bit u1, u2;
    u1 = is_known(instr_id) && !(instr_id[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111});
    u2 = instr_id[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
    return !rst && id_valid && m_ex.v && m_ex.mr && (m_ex.rd != 0) && !flush_ex && !hold
           && ((u1 && instr_id[19:15] == m_ex.rd) || (u2 && instr_id[24:20] == m_ex.rd));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ex <= '0; m_mem <= '0; m_wb <= '0; m_ok <= 1'b1;
    end else if (!hold) begin
      m_wb  <= m_mem;
      m_mem <= m_ex;
      m_ex  <= (id_valid && !flush_ex && !exp_stall() && !exp_illegal()) ? model_dec(instr_id) : '0;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("model_stall", 32'(stall_out), 32'(exp_stall()));
      check("model_illegal", 32'(illegal_id), 32'(exp_illegal()));
      check("model_ex", 32'({ex_valid, ex_alu_op, ex_alu_src, ex_alu_src_a, ex_branch, ex_is_jal,
                             ex_is_jalr, ex_is_lui, ex_rd}),
            32'({m_ex.v, m_ex.op, m_ex.src, m_ex.srca, m_ex.br, m_ex.jal, m_ex.jalr, m_ex.lui,
                 m_ex.rd}));
      check("model_mem", 32'({mem_read, mem_write, mem_reg_write, mem_rd}),
            32'({m_mem.mr, m_mem.mw, m_mem.rw, m_mem.rd}));
      check("model_wb", 32'({wb_reg_write, wb_memto_reg, wb_rd}),
            32'({m_wb.rw, m_wb.m2r, m_wb.rd}));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] ins);
    instr_id = ins;
    id_valid = 1'b1;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({stall_out, illegal_id, ex_valid, ex_alu_op, ex_alu_src, ex_alu_src_a, ex_branch,
                ex_is_jal, ex_is_jalr, ex_is_lui, ex_rd, mem_read, mem_write, mem_reg_write,
                mem_rd, wb_reg_write, wb_memto_reg, wb_rd});
  endfunction

  initial begin
    rst = 1'b1; hold = 1'b0; flush_ex = 1'b0; id_valid = 1'b1; instr_id = $urandom;
    for (int i = 0; i < 2; i++) begin
      tick();
      instr_id = $urandom;
      #1;
      check("reset_outputs_zero", all_outs(), 32'd0);
    end
    rst = 1'b0;

    // Latency: ADDI x5 in ID at cycle 0
    present(ADDI_X5);
    tick();
    id_valid = 1'b0;
    check("lat_ex", 32'({ex_valid, ex_alu_op, ex_alu_src, ex_rd}), 32'({1'b1, 2'd2, 1'b1, 5'd5}));
    tick();
    check("lat_mem", 32'({mem_reg_write, mem_rd}), 32'({1'b1, 5'd5}));
    tick();
    check("lat_wb", 32'({wb_reg_write, wb_memto_reg, wb_rd}), 32'({1'b1, 1'b0, 5'd5}));

    // Load-use on rs1
    present(LW_X3);
    tick();
    present(ADD_X4);
    #1;
    check("lu_stall", 32'(stall_out), 32'd1);
    tick();
    check("lu_bubble", 32'({ex_valid, stall_out, mem_read, mem_rd}), 32'({1'b0, 1'b0, 1'b1, 5'd3}));
    tick();
    check("lu_add_in_ex", 32'({ex_valid, ex_alu_op, ex_rd}), 32'({1'b1, 2'd2, 5'd4}));

    // Load-use on rs2 (store data)
    present(LW_X3);
    tick();
    present(SW_X3);
    #1;
    check("lu_rs2_stall", 32'(stall_out), 32'd1);
    tick();
    tick();

    // No false stalls
    present(LW_X3);
    tick();
    present(LUI_X3);
    #1;
    check("nostall_lui", 32'(stall_out), 32'd0);
    tick();
    present(LW_X3);
    tick();
    present(JAL_X1);
    #1;
    check("nostall_jal", 32'(stall_out), 32'd0);
    tick();
    present(LW_X0);
    tick();
    present(ADD_X4_0);
    #1;
    check("nostall_x0", 32'(stall_out), 32'd0);
    tick();

    // Flush beats stall
    present(LW_X3);
    tick();
    present(ADD_X4);
    flush_ex = 1'b1;
    #1;
    check("flush_no_stall", 32'(stall_out), 32'd0);
    tick();
    flush_ex = 1'b0;
    check("flush_bubble", 32'({ex_valid, mem_read, mem_rd}), 32'({1'b0, 1'b1, 5'd3}));

    // Hold mid-stream: EX=BEQ, MEM=ADD x4, WB=ADDI x5
    present(ADDI_X5); tick();
    present(ADD_X4);  tick();
    present(BEQ);     tick();
    present(JALR_X1);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_frozen", 32'({ex_valid, ex_branch, ex_alu_op, mem_reg_write, mem_rd, wb_reg_write,
                                wb_rd, stall_out}),
            32'({1'b1, 1'b1, 2'd1, 1'b1, 5'd4, 1'b1, 5'd5, 1'b0}));
    end
    hold = 1'b0;
    tick();
    check("hold_resume", 32'({ex_is_jalr, ex_rd, mem_reg_write, wb_rd}), 32'({1'b1, 5'd1, 1'b0, 5'd4}));

    // Hold masks a pending load-use
    present(LW_X3); tick();
    present(ADD_X4);
    hold = 1'b1;
    #1;
    check("hold_no_stall", 32'(stall_out), 32'd0);
    tick();
    hold = 1'b0;
    #1;
    check("post_hold_stall", 32'(stall_out), 32'd1);
    tick(); tick();

    // Remaining opcodes
    present(AUIPC_X6); tick();
    check("auipc_ex", 32'({ex_alu_src_a, ex_alu_op, ex_rd}), 32'({1'b1, 2'd3, 5'd6}));
    present(NOP); tick();
    present(SW_X3); tick();
    tick();
    check("nop_no_write", 32'({wb_reg_write, mem_write}), 32'({1'b0, 1'b1}));

    // Unsupported encodings
    present(32'h00000000);
`ifdef CTRL_ILLEGAL_TRAP_EN
    #1;
    check("illegal_flag", 32'(illegal_id), 32'd1);
    tick();
    check("illegal_bubble", 32'(ex_valid), 32'd0);
`else
    #1;
    check("illegal_flag_off", 32'(illegal_id), 32'd0);
    tick();
    check("unknown_passes", 32'({ex_valid, ex_alu_op, ex_alu_src}), 32'({1'b1, 2'd0, 1'b0}));
`endif
    present(LW_X3); tick();
    present(BAD_RS1);
    #1;
    check("unknown_no_stall", 32'(stall_out), 32'd0);
    tick();

    // Reset mid-operation
    present(ADDI_X5); tick();
    present(LW_X3);   tick();
    present(ADD_X4);
    rst = 1'b1;
    tick();
    check("midrst_zero", all_outs(), 32'd0);
    rst = 1'b0;
    id_valid = 1'b0;
    tick(); tick();
    check("midrst_drained", 32'({ex_valid, mem_reg_write, wb_reg_write}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
